// File: rtl/ir_nec_decoder.sv
// NEC infrared frame decoder with an Avalon-MM register interface (CTRL, STATUS, DATA, RPTCNT).
// Define IR_NEC_CHECK_EN to reject frames whose address/command inverse bytes do not match.
module ir_nec_decoder #(
    parameter int TICK_DIV      = 500,
    parameter int TIMEOUT_TICKS = 1100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ir_in,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic        read_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);

    localparam int             PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [10:0]    TO      = 11'(TIMEOUT_TICKS);

    typedef enum logic [2:0] {
        IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK
    } state_t;

    logic [1:0]    sync_reg;
    logic          filt_reg, filt_d_reg;
    logic [1:0]    fcnt_reg;
    logic [PW-1:0] pre_reg;
    logic          tick_reg;
    logic [10:0]   cnt_reg;
    state_t        state_reg;
    logic [4:0]    bitcnt_reg;
    logic [31:0]   shift_reg;
    logic          rpt_frame_reg;
    logic          en_reg, irq_en_reg;
    logic          valid_reg, rpt_reg, err_reg, ovr_reg;
    logic [31:0]   data_reg;
    logic [15:0]   rptcnt_reg;
    logic [31:0]   rd_mux;

    logic rise, fall, wr, rd;
    assign rise = filt_reg & ~filt_d_reg;
    assign fall = ~filt_reg & filt_d_reg;
    assign wr   = chipselect & ~write_n;
    assign rd   = chipselect & ~read_n;
    assign irq  = valid_reg & irq_en_reg;

    logic unused_bits;
    assign unused_bits = ^writedata[31:4];

    function automatic logic in_rng(input logic [10:0] c, input int lo, input int hi);
        return (int'(c) >= lo) && (int'(c) <= hi);
    endfunction

    // Synchronizer plus a 4-sample persistence filter; idle line is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg   <= 2'b11;
            filt_reg   <= 1'b1;
            filt_d_reg <= 1'b1;
            fcnt_reg   <= 2'd0;
        end else begin
            sync_reg   <= {sync_reg[0], ir_in};
            filt_d_reg <= filt_reg;
            if (sync_reg[1] == filt_reg) begin
                fcnt_reg <= 2'd0;
            end else if (fcnt_reg == 2'd3) begin
                filt_reg <= sync_reg[1];
                fcnt_reg <= 2'd0;
            end else begin
                fcnt_reg <= fcnt_reg + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_reg  <= '0;
            tick_reg <= 1'b0;
            cnt_reg  <= 11'd0;
        end else begin
            if (pre_reg == PRE_MAX) begin
                pre_reg  <= '0;
                tick_reg <= 1'b1;
            end else begin
                pre_reg  <= pre_reg + 1'b1;
                tick_reg <= 1'b0;
            end
            if (rise || fall)
                cnt_reg <= 11'd0;
            else if (tick_reg && cnt_reg < TO)
                cnt_reg <= cnt_reg + 11'd1;
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        case (address)
            2'd0: rd_mux[1:0] = {irq_en_reg, en_reg};
            2'd1: rd_mux[3:0] = {ovr_reg, err_reg, rpt_reg, valid_reg};
            2'd2: rd_mux      = data_reg;
            default: rd_mux[15:0] = rptcnt_reg;
        endcase
    end

    // Bus writes come first so that flag sets from the decoder below win over W1C.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            bitcnt_reg    <= 5'd0;
            shift_reg     <= 32'd0;
            rpt_frame_reg <= 1'b0;
            en_reg        <= 1'b0;
            irq_en_reg    <= 1'b0;
            valid_reg     <= 1'b0;
            rpt_reg       <= 1'b0;
            err_reg       <= 1'b0;
            ovr_reg       <= 1'b0;
            data_reg      <= 32'd0;
            rptcnt_reg    <= 16'd0;
            readdata      <= 32'd0;
        end else begin
            if (rd)
                readdata <= rd_mux;
            if (wr && address == 2'd0) begin
                en_reg     <= writedata[0];
                irq_en_reg <= writedata[1];
            end
            if (wr && address == 2'd1) begin
                if (writedata[0]) valid_reg <= 1'b0;
                if (writedata[1]) rpt_reg   <= 1'b0;
                if (writedata[2]) err_reg   <= 1'b0;
                if (writedata[3]) ovr_reg   <= 1'b0;
            end

            if (!en_reg) begin
                state_reg <= IDLE;
            end else if (state_reg != IDLE && cnt_reg >= TO) begin
                state_reg <= IDLE;
                err_reg   <= 1'b1;
            end else begin
                case (state_reg)
                    IDLE: if (fall) state_reg <= LEAD_MARK;
                    LEAD_MARK: if (rise) begin
                        if (in_rng(cnt_reg, 800, 1000)) state_reg <= LEAD_SPACE;
                        else begin state_reg <= IDLE; err_reg <= 1'b1; end
                    end
                    LEAD_SPACE: if (fall) begin
                        if (in_rng(cnt_reg, 400, 500)) begin
                            state_reg     <= BIT_MARK;
                            bitcnt_reg    <= 5'd0;
                            rpt_frame_reg <= 1'b0;
                        end else if (in_rng(cnt_reg, 200, 250)) begin
                            state_reg     <= STOP_MARK;
                            rpt_frame_reg <= 1'b1;
                        end else begin
                            state_reg <= IDLE;
                            err_reg   <= 1'b1;
                        end
                    end
                    BIT_MARK: if (rise) begin
                        if (in_rng(cnt_reg, 40, 72)) state_reg <= BIT_SPACE;
                        else begin state_reg <= IDLE; err_reg <= 1'b1; end
                    end
                    BIT_SPACE: if (fall) begin
                        if (in_rng(cnt_reg, 40, 72) || in_rng(cnt_reg, 140, 200)) begin
                            shift_reg  <= {in_rng(cnt_reg, 140, 200), shift_reg[31:1]};
                            bitcnt_reg <= bitcnt_reg + 5'd1;
                            state_reg  <= (bitcnt_reg == 5'd31) ? STOP_MARK : BIT_MARK;
                        end else begin
                            state_reg <= IDLE;
                            err_reg   <= 1'b1;
                        end
                    end
                    STOP_MARK: if (rise) begin
                        state_reg <= IDLE;
                        if (!in_rng(cnt_reg, 40, 72)) begin
                            err_reg <= 1'b1;
                        end else if (rpt_frame_reg) begin
                            if (valid_reg) begin
                                rpt_reg <= 1'b1;
                                if (rptcnt_reg != 16'hFFFF) rptcnt_reg <= rptcnt_reg + 16'd1;
                            end
                        end
`ifdef IR_NEC_CHECK_EN
                        else if (shift_reg[7:0] != ~shift_reg[15:8] ||
                                 shift_reg[23:16] != ~shift_reg[31:24]) begin
                            err_reg <= 1'b1;
                        end
`endif
                        else begin
                            if (valid_reg) ovr_reg <= 1'b1;
                            data_reg   <= shift_reg;
                            valid_reg  <= 1'b1;
                            rpt_reg    <= 1'b0;
                            rptcnt_reg <= 16'd0;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ir_nec_decoder.sv
// Bench for ir_nec_decoder: randomized NEC waveforms against an abstract register-level model.
module tb_ir_nec_decoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ir_in = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic        read_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        irq;

    int total = 0;
    int bad = 0;

    // Abstract model of the visible register state.
    logic [1:0]  m_ctrl = 2'd0;
    logic        m_valid = 1'b0, m_rpt = 1'b0, m_err = 1'b0, m_ovr = 1'b0;
    logic [31:0] m_data = 32'd0;
    logic [15:0] m_rptcnt = 16'd0;

    logic [31:0] r_ctrl, r_st, r_data, r_rc;

    ir_nec_decoder #(.TICK_DIV(1), .TIMEOUT_TICKS(1100)) dut (
        .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .address(address),
        .chipselect(chipselect), .write_n(write_n), .read_n(read_n),
        .writedata(writedata), .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_status();
        return {28'd0, m_ovr, m_err, m_rpt, m_valid};
    endfunction

    task automatic m_frame(input logic [31:0] w);
`ifdef IR_NEC_CHECK_EN
        if (w[7:0] != ~w[15:8] || w[23:16] != ~w[31:24]) begin
            m_err = 1'b1;
            return;
        end
`endif
        if (m_valid) m_ovr = 1'b1;
        m_data = w; m_valid = 1'b1; m_rpt = 1'b0; m_rptcnt = 16'd0;
    endtask

    task automatic m_repeat();
        if (m_valid) begin
            m_rpt = 1'b1;
            if (m_rptcnt != 16'hFFFF) m_rptcnt = m_rptcnt + 16'd1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; read_n = 1'b0; address = a;
        @(negedge clk);
        d = readdata;
        chipselect = 1'b0; read_n = 1'b1;
    endtask

    task automatic read_all();
        bus_read(2'd0, r_ctrl);
        bus_read(2'd1, r_st);
        bus_read(2'd2, r_data);
        bus_read(2'd3, r_rc);
    endtask

    task automatic mark(input int n);
        ir_in = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic space(input int n, input bit glitch);
        ir_in = 1'b1;
        if (glitch) begin
            repeat (n / 2) @(negedge clk);
            ir_in = 1'b0;
            repeat (2) @(negedge clk);
            ir_in = 1'b1;
            repeat (n - n / 2 - 2) @(negedge clk);
        end else begin
            repeat (n) @(negedge clk);
        end
    endtask

    // nbits < 32 stops mid-frame right after that bit's space, line left high.
    task automatic send_frame(input logic [31:0] w, input bit glitch, input int nbits);
        mark(int'($urandom_range(850, 950)));
        space(int'($urandom_range(420, 480)), 1'b0);
        for (int i = 0; i < nbits; i++) begin
            mark(int'($urandom_range(50, 62)));
            if (w[i]) space(int'($urandom_range(150, 175)), glitch);
            else      space(int'($urandom_range(50, 62)), glitch);
        end
        if (nbits == 32) begin
            mark(int'($urandom_range(50, 62)));
            space(40, 1'b0);
        end
    endtask

    task automatic send_repeat();
        mark(int'($urandom_range(850, 950)));
        space(int'($urandom_range(210, 240)), 1'b0);
        mark(int'($urandom_range(50, 62)));
        space(40, 1'b0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (readdata !== 32'd0 || irq !== 1'b0) begin bad++;
            $display("FAIL reset_outputs got rd=%h irq=%b exp rd=0 irq=0", readdata, irq); end
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        read_all();
        total++; if ({r_ctrl, r_st, r_data, r_rc} !== 128'd0) begin bad++;
            $display("FAIL reset_regs got %h %h %h %h exp all 0", r_ctrl, r_st, r_data, r_rc); end
    endtask

    task automatic test_frame();
        bus_write(2'd0, 32'h3); m_ctrl = 2'd3;
        send_frame(32'hF708FB04, 1'b0, 32); m_frame(32'hF708FB04);
        read_all();
        total++; if (r_ctrl !== 32'h3) begin bad++; $display("FAIL frame_ctrl got=%h exp=3", r_ctrl); end
        total++; if (r_data !== 32'hF708FB04) begin bad++; $display("FAIL frame_data got=%h exp=F708FB04", r_data); end
        total++; if (r_st !== 32'h1) begin bad++; $display("FAIL frame_status got=%h exp=1", r_st); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL frame_irq got=%b exp=1", irq); end
    endtask

    task automatic test_repeat();
        for (int i = 0; i < 3; i++) begin send_repeat(); m_repeat(); end
        read_all();
        total++; if (r_rc !== {16'd0, m_rptcnt}) begin bad++; $display("FAIL rpt_count got=%h exp=%h", r_rc, m_rptcnt); end
        total++; if (r_st !== m_status()) begin bad++; $display("FAIL rpt_status got=%h exp=%h", r_st, m_status()); end
        bus_write(2'd1, 32'hF); m_valid = 0; m_rpt = 0; m_err = 0; m_ovr = 0;
        bus_read(2'd1, r_st);
        total++; if (r_st !== 32'h0) begin bad++; $display("FAIL w1c_status got=%h exp=0", r_st); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL w1c_irq got=%b exp=0", irq); end
    endtask

    task automatic test_repeat_ignored();
        send_repeat(); m_repeat();
        read_all();
        total++; if (r_rc !== {16'd0, m_rptcnt} || r_st !== m_status()) begin bad++;
            $display("FAIL rpt_ignored got rc=%h st=%h exp rc=%h st=%h", r_rc, r_st, m_rptcnt, m_status()); end
    endtask

    task automatic test_bad_lead();
        mark(700); space(60, 1'b0); m_err = 1'b1;
        bus_read(2'd1, r_st);
        total++; if (r_st !== m_status()) begin bad++; $display("FAIL bad_lead got=%h exp=%h", r_st, m_status()); end
        bus_write(2'd1, 32'h4); m_err = 1'b0;
    endtask

    task automatic test_timeout();
        logic [31:0] w;
        w = {~8'h3C, 8'h3C, ~8'hA5, 8'hA5};
        mark(900); space(450, 1'b0); mark(1200); space(60, 1'b0); m_err = 1'b1;
        bus_read(2'd1, r_st);
        total++; if (r_st !== m_status()) begin bad++; $display("FAIL timeout got=%h exp=%h", r_st, m_status()); end
        bus_write(2'd1, 32'h4); m_err = 1'b0;
        send_frame(w, 1'b0, 32); m_frame(w);
        read_all();
        total++; if (r_data !== m_data || r_st !== m_status()) begin bad++;
            $display("FAIL after_timeout got d=%h st=%h exp d=%h st=%h", r_data, r_st, m_data, m_status()); end
    endtask

    task automatic test_overrun();
        logic [31:0] w;
        w = 32'h12345678;
        send_frame(w, 1'b0, 32); m_frame(w);
        read_all();
        total++; if (r_data !== m_data || r_st !== m_status() || r_rc !== {16'd0, m_rptcnt}) begin bad++;
            $display("FAIL overrun got d=%h st=%h rc=%h exp d=%h st=%h rc=%h",
                     r_data, r_st, r_rc, m_data, m_status(), m_rptcnt); end
        bus_write(2'd1, 32'hF); m_valid = 0; m_rpt = 0; m_err = 0; m_ovr = 0;
    endtask

    task automatic test_bad_inverse();
        send_frame(32'h0008FB04, 1'b0, 32); m_frame(32'h0008FB04);
        read_all();
        total++; if (r_data !== m_data || r_st !== m_status()) begin bad++;
            $display("FAIL bad_inverse got d=%h st=%h exp d=%h st=%h", r_data, r_st, m_data, m_status()); end
    endtask

    task automatic test_en_abort();
        send_frame(32'hFFFF0000, 1'b0, 8);
        bus_write(2'd0, 32'h2); m_ctrl = 2'd2;
        repeat (30) @(negedge clk);
        read_all();
        total++; if (r_st !== m_status() || r_data !== m_data || r_ctrl !== {30'd0, m_ctrl}) begin bad++;
            $display("FAIL en_abort got st=%h d=%h c=%h exp st=%h d=%h c=%h",
                     r_st, r_data, r_ctrl, m_status(), m_data, m_ctrl); end
        bus_write(2'd1, 32'hF); m_valid = 0; m_rpt = 0; m_err = 0; m_ovr = 0;
        bus_write(2'd0, 32'h3); m_ctrl = 2'd3;
    endtask

    task automatic test_glitch();
        logic [31:0] w;
        w = {~8'hC3, 8'hC3, ~8'h5A, 8'h5A};
        send_frame(w, 1'b1, 32); m_frame(w);
        read_all();
        total++; if (r_data !== m_data || r_st !== m_status()) begin bad++;
            $display("FAIL glitch got d=%h st=%h exp d=%h st=%h", r_data, r_st, m_data, m_status()); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] w;
        w = {~8'h81, 8'h81, ~8'h7E, 8'h7E};
        send_frame(32'h55AA55AA, 1'b0, 16);
        reset_n = 1'b0; ir_in = 1'b1;
        #1;
        total++; if (readdata !== 32'd0 || irq !== 1'b0) begin bad++;
            $display("FAIL midreset_out got rd=%h irq=%b exp 0 0", readdata, irq); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        m_ctrl = 0; m_valid = 0; m_rpt = 0; m_err = 0; m_ovr = 0; m_data = 0; m_rptcnt = 0;
        repeat (10) @(negedge clk);
        read_all();
        total++; if ({r_ctrl, r_st, r_data, r_rc} !== 128'd0) begin bad++;
            $display("FAIL midreset_regs got %h %h %h %h exp all 0", r_ctrl, r_st, r_data, r_rc); end
        bus_write(2'd0, 32'h3); m_ctrl = 2'd3;
        send_frame(w, 1'b0, 32); m_frame(w);
        read_all();
        total++; if (r_data !== m_data || r_st !== m_status() || irq !== 1'b1) begin bad++;
            $display("FAIL midreset_next got d=%h st=%h irq=%b exp d=%h st=%h irq=1",
                     r_data, r_st, irq, m_data, m_status()); end
    endtask

    task automatic test_random();
        logic [7:0] a, c;
        logic [31:0] w;
        a = 8'($urandom_range(0, 255));
        c = 8'($urandom_range(0, 255));
        w = {~c, c, ~a, a};
        send_frame(w, 1'b0, 32); m_frame(w);
        read_all();
        total++; if (r_data !== m_data || r_st !== m_status() || r_rc !== {16'd0, m_rptcnt}) begin bad++;
            $display("FAIL random got d=%h st=%h rc=%h exp d=%h st=%h rc=%h",
                     r_data, r_st, r_rc, m_data, m_status(), m_rptcnt); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_repeat();
        test_repeat_ignored();
        test_bad_lead();
        test_timeout();
        test_overrun();
        test_bad_inverse();
        test_en_abort();
        test_glitch();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
